iterative_lsl: RTL and testbench

- Multi-cycle 32-bit logical shift-left unit: the left-shift counterpart of the ALU's combinational logical shift-right.
- Shifts one bit position per clock under a start/busy/done handshake.
- Sits beside the ALU datapath. Used where a single-cycle barrel shifter is not wanted (area), and as the sequential LSL operation of the ALU.

---
 rtl/alu_pkg.sv | 18 +
 rtl/iterative_lsl.sv | 79 +++++++
 tb/tb_iterative_lsl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : constants and state encoding shared by the ALU shift units
// Revision: 1.0
// ============================================================================
package alu_pkg;

   localparam int WORD_W  = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } lsl_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/iterative_lsl.sv
`default_nettype none
// ============================================================================
// iterative_lsl : multi-cycle logical shift-left, one bit per clock
// Revision: 1.0
// ============================================================================
module iterative_lsl
   import alu_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int SHW   = SHAMT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] Rin,
   input  logic [SHW-1:0]   n,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Rx,
   output logic             cout,
   output logic             zero
);

   lsl_state_e       state_q, state_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             cout_q, cout_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rx_q    <= '0;
         cnt_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         cout_q  <= cout_d;
      end
   end

   // The edge that sees cnt==0 only moves to DONE, giving uniform n+1 latency.
   always_comb begin
      state_d = state_q;
      rx_d    = rx_q;
      cnt_d   = cnt_q;
      cout_d  = cout_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               rx_d    = Rin;
               cnt_d   = n;
               cout_d  = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               rx_d   = {rx_q[WIDTH-2:0], 1'b0};
               cout_d = rx_q[WIDTH-1];
               cnt_d  = cnt_q - SHW'(1);
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign Rx   = rx_q;
   assign cout = cout_q;
   assign zero = (rx_q == '0);

endmodule : iterative_lsl
`default_nettype wire

// File: tb/tb_iterative_lsl.sv
`default_nettype none
// ============================================================================
// tb_iterative_lsl : directed-vector bench for iterative_lsl
// Revision: 1.0
// ============================================================================
module tb_iterative_lsl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] Rin;
   logic [4:0]  n;
   logic        busy;
   logic        done;
   logic [31:0] Rx;
   logic        cout;
   logic        zero;

   int vectors;
   int miscompares;

   iterative_lsl #(.WIDTH(32), .SHW(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .Rin   (Rin),
      .n     (n),
      .busy  (busy),
      .done  (done),
      .Rx    (Rx),
      .cout  (cout),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launches one operation; optionally pokes a second start while busy at cycle poke_at.
   task automatic run_op(input string tag, input logic [31:0] rin, input logic [4:0] sh,
                         input logic [31:0] exp_rx, input logic exp_cout,
                         input logic exp_zero, input int poke_at);
      int k;
      int lat;
      start = 1'b1;
      Rin   = rin;
      n     = sh;
      @(posedge clk);
      #1;
      start = 1'b0;
      Rin   = 32'hA5A5_5A5A;
      n     = 5'd7;
      lat   = -1;
      for (k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         start = (k == poke_at);
         if (poke_at > 0) begin
            Rin = 32'h1;
            n   = 5'd3;
         end
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
      check({tag, " latency"}, lat, sh + 1);
      check({tag, " Rx"},      Rx,   exp_rx);
      check({tag, " cout"},    cout, exp_cout);
      check({tag, " zero"},    zero, exp_zero);
      @(posedge clk);
      #1;
      check({tag, " done pulse ends"}, done, 1'b0);
      check({tag, " busy after"},      busy, 1'b0);
      @(posedge clk);
      #1;
      check({tag, " no second done"},  done, 1'b0);
      check({tag, " Rx held"},         Rx,   exp_rx);
   endtask

   initial begin
      int seen_done;
      vectors     = 0;
      miscompares = 0;
      rst   = 1'b1;
      start = 1'b1;
      Rin   = 32'hFFFF_FFFF;
      n     = 5'd3;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset Rx",   Rx,   32'h0);
      check("reset cout", cout, 1'b0);
      check("reset zero", zero, 1'b1);
      start = 1'b0;
      rst   = 1'b0;
      @(posedge clk);
      #1;
      check("idle after reset", busy, 1'b0);

      run_op("n1",       32'h0000_0003, 5'd1,  32'h0000_0006, 1'b0, 1'b0, 0);
      run_op("n5",       32'h000E_1AE1, 5'd5,  32'h01C3_5C20, 1'b0, 1'b0, 0);
      run_op("n31",      32'h0000_0003, 5'd31, 32'h8000_0000, 1'b1, 1'b0, 0);
      run_op("n0",       32'h0000_000F, 5'd0,  32'h0000_000F, 1'b0, 1'b0, 0);
      run_op("msb out",  32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1, 1'b1, 0);
      run_op("busy poke",32'hFFFF_FFFF, 5'd12, 32'hFFFF_F000, 1'b1, 1'b0, 3);

      // Abort: start n=20 at E0, rst sampled at edge E0+4.
      start = 1'b1;
      Rin   = 32'h1234_5678;
      n     = 5'd20;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort busy before rst", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort Rx",   Rx,   32'h0);
      check("abort cout", cout, 1'b0);
      check("abort zero", zero, 1'b1);
      seen_done = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done++;
      end
      check("abort no activity", seen_done, 0);

      run_op("after abort", 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_iterative_lsl
`default_nettype wire
